// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit for the execute stage (RV64M + W ops).
//
// Multiply is shift-add, MSB-first, one multiplier bit per cycle. Divide is
// restoring division, one quotient bit per cycle. Signed ops iterate on
// magnitudes; the result sign is applied in the finishing cycle.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE, and result is held stable until the transfer. flush
// overrides both handshakes: a request presented with flush is not taken.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous cancel, forces IDLE on the next edge
//   in_valid/in_ready, op, a, b     request side
//   out_valid/out_ready, result     response side (result is registered)
//   busy            high in BUSY or DONE
//   dbg_state       current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module mdu_iter #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [OPW-1:0] OP_MUL    = OPW'(0);
  localparam logic [OPW-1:0] OP_MULH   = OPW'(1);
  localparam logic [OPW-1:0] OP_MULHSU = OPW'(2);
  localparam logic [OPW-1:0] OP_MULHU  = OPW'(3);
  localparam logic [OPW-1:0] OP_DIV    = OPW'(4);
  localparam logic [OPW-1:0] OP_REM    = OPW'(6);
  localparam logic [OPW-1:0] OP_REMU   = OPW'(7);
  localparam logic [OPW-1:0] OP_MULW   = OPW'(8);
  localparam logic [OPW-1:0] OP_DIVW   = OPW'(9);
  localparam logic [OPW-1:0] OP_REMW   = OPW'(11);
  localparam logic [OPW-1:0] OP_REMUW  = OPW'(12);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Op decode helpers
  // ---------------------------------------------------------------------
  function automatic logic f_illegal(input logic [OPW-1:0] o);
    return (o > OP_REMUW) || ((XLEN == 32) && (o >= OP_MULW));
  endfunction

  function automatic logic f_is_w(input logic [OPW-1:0] o);
    return (XLEN > 32) && (o >= OP_MULW) && (o <= OP_REMUW);
  endfunction

  function automatic logic f_is_mul(input logic [OPW-1:0] o);
    return (o <= OP_MULHU) || (o == OP_MULW);
  endfunction

  function automatic logic f_is_rem(input logic [OPW-1:0] o);
    return (o == OP_REM) || (o == OP_REMU) || (o == OP_REMW) || (o == OP_REMUW);
  endfunction

  function automatic logic f_b_signed(input logic [OPW-1:0] o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM) ||
           (o == OP_DIVW) || (o == OP_REMW);
  endfunction

  function automatic logic f_a_signed(input logic [OPW-1:0] o);
    return f_b_signed(o) || (o == OP_MULHSU);
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = {XLEN{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = x;
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t              state_q,  state_d;
  logic [CW-1:0]       cnt_q,    cnt_d;
  logic [OPW-1:0]      op_q,     op_d;
  logic                negq_q,   negq_d;   // quotient / product sign
  logic                negr_q,   negr_d;   // remainder sign
  logic [XLEN-1:0]     opa_q,    opa_d;    // multiplier / dividend, then quotient
  logic [XLEN-1:0]     opb_q,    opb_d;    // multiplicand / divisor magnitude
  logic [2*XLEN-1:0]   acc_q,    acc_d;    // product / partial remainder (low half)
  logic [XLEN-1:0]     result_q, result_d;

  // ---------------------------------------------------------------------
  // Request-side decode (valid only while IDLE)
  // ---------------------------------------------------------------------
  logic            is_w_in;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_res;
  logic            a_neg, b_neg;
  logic            is_min, is_m1, div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] opa_load;

  always_comb begin
    is_w_in = f_is_w(op);
    a_ext   = a;
    b_ext   = b;
    if (is_w_in) begin
      a_ext = f_a_signed(op) ? sext32(a[31:0]) : zext32(a[31:0]);
      b_ext = f_b_signed(op) ? sext32(b[31:0]) : zext32(b[31:0]);
    end
    a_neg = f_a_signed(op) & a_ext[XLEN-1];
    b_neg = f_b_signed(op) & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    // W magnitudes fit in 32 bits; park them at the top so the MSB-first
    // iteration finishes after 32 steps.
    opa_load = is_w_in ? (a_mag << (XLEN - 32)) : a_mag;

    // Dividend as returned by the fast paths (W forms are sign-extended
    // from bit 31 regardless of signedness).
    a_res  = is_w_in ? sext32(a[31:0]) : a;
    is_min = is_w_in ? (a[31:0] == 32'h8000_0000) : (a == {1'b1, {(XLEN-1){1'b0}}});
    is_m1  = is_w_in ? (&b[31:0]) : (&b);

    div_zero = ~f_is_mul(op) & (b_ext == '0);
    div_ovf  = ~f_is_mul(op) & f_b_signed(op) & is_min & is_m1;
    fast     = f_illegal(op) | div_zero | div_ovf;

    fast_res = '0;
    if (f_illegal(op)) begin
      fast_res = '0;
    end else if (div_zero) begin
      fast_res = f_is_rem(op) ? a_res : '1;
    end else if (div_ovf) begin
      fast_res = f_is_rem(op) ? '0 : a_res;
    end
  end

  // ---------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     rshift, diff;
  logic [2*XLEN-1:0] div_acc;
  logic [XLEN-1:0]   div_opa;

  always_comb begin
    mul_acc = {acc_q[2*XLEN-2:0], 1'b0} +
              (opa_q[XLEN-1] ? {{XLEN{1'b0}}, opb_q} : {(2*XLEN){1'b0}});

    // Restoring step: the borrow out of diff[XLEN] says the trial subtract
    // failed, so the shifted remainder is kept unchanged.
    rshift  = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    diff    = rshift - {1'b0, opb_q};
    div_acc = {{XLEN{1'b0}}, (diff[XLEN] ? rshift[XLEN-1:0] : diff[XLEN-1:0])};
    div_opa = {opa_q[XLEN-2:0], ~diff[XLEN]};
  end

  // ---------------------------------------------------------------------
  // Finishing: apply signs and select the result
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, div_v, fin_res;

  always_comb begin
    prod  = negq_q ? -acc_q : acc_q;
    quo   = negq_q ? -opa_q : opa_q;
    rem   = negr_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    div_v = f_is_rem(op_q) ? rem : quo;

    fin_res = '0;
    if (f_is_mul(op_q)) begin
      if (op_q == OP_MUL) begin
        fin_res = prod[XLEN-1:0];
      end else if (op_q == OP_MULW) begin
        fin_res = sext32(prod[31:0]);
      end else begin
        fin_res = prod[2*XLEN-1:XLEN];
      end
    end else begin
      fin_res = f_is_w(op_q) ? sext32(div_v[31:0]) : div_v;
    end
  end

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d = op;
            if (fast) begin
              result_d = fast_res;
              state_d  = S_DONE;
            end else begin
              opa_d   = opa_load;
              opb_d   = b_mag;
              acc_d   = '0;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              cnt_d   = is_w_in ? CW'(32) : CW'(XLEN);
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // cnt counts remaining iterations; the cycle after it hits zero
          // applies the sign and writes the result.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (f_is_mul(op_q)) begin
              acc_d = mul_acc;
              opa_d = opa_q << 1;
            end else begin
              acc_d = div_acc;
              opa_d = div_opa;
            end
          end else begin
            result_d = fin_res;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY) || (state_q == S_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter (XLEN=64): directed cases, flush/reset/backpressure
// scenarios and randomized ops checked against an arithmetic reference.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  op;
  logic [63:0] a, b, result;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mdu_iter #(.XLEN(64), .OPW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [127:0]       p;
    logic signed [63:0] sx, sy, sq;
    logic signed [31:0] wx, wy, wq;
    logic [31:0]        ux, uy;
    logic               ovf64, ovf32;
    sx = x; sy = y;
    ux = x[31:0]; uy = y[31:0];
    wx = ux; wy = uy;
    ovf64 = (x == MIN64) && (y == ONES);
    ovf32 = (ux == 32'h8000_0000) && (uy == 32'hFFFF_FFFF);
    case (o)
      4'd0: begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; return p[63:0]; end
      4'd1: begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; return p[127:64]; end
      4'd2: begin p = {{64{x[63]}}, x} * {64'd0, y};       return p[127:64]; end
      4'd3: begin p = {64'd0, x} * {64'd0, y};             return p[127:64]; end
      4'd4: begin
        if (y == 0) return ONES;
        if (ovf64) return x;
        sq = sx / sy; return sq;
      end
      4'd5: return (y == 0) ? ONES : x / y;
      4'd6: begin
        if (y == 0) return x;
        if (ovf64) return 64'd0;
        sq = sx % sy; return sq;
      end
      4'd7: return (y == 0) ? x : x % y;
      4'd8: return sx32(ux * uy);
      4'd9: begin
        if (uy == 0) return ONES;
        if (ovf32) return sx32(ux);
        wq = wx / wy; return sx32(wq);
      end
      4'd10: return (uy == 0) ? ONES : sx32(ux / uy);
      4'd11: begin
        if (uy == 0) return sx32(ux);
        if (ovf32) return 64'd0;
        wq = wx % wy; return sx32(wq);
      end
      4'd12: return (uy == 0) ? sx32(ux) : sx32(ux % uy);
      default: return 64'd0;
    endcase
  endfunction

  // Edges after the accepting edge until out_valid is first seen high.
  function automatic int ref_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    logic fast;
    fast = (o > 4'd12);
    if (o >= 4'd4 && o <= 4'd7)
      fast = (y == 0) || ((o == 4'd4 || o == 4'd6) && x == MIN64 && y == ONES);
    if (o >= 4'd9 && o <= 4'd12)
      fast = (y[31:0] == 0) ||
             ((o == 4'd9 || o == 4'd11) && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
    if (fast) return 0;
    return (o >= 4'd8) ? 33 : 65;
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input string tag, input logic [3:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] expv, input int hold);
    int lat;
    int exp_lat;
    logic [63:0] e;
    exp_lat = ref_lat(o, x, y);
    @(negedge clk);
    check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    // Scramble inputs after the accept; the unit must ignore them.
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    check_eq({tag, "_result"}, result, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check_eq({tag, "_hold_result"}, result, e);
      check_eq({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_drop_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_idle_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  ro;
    logic [63:0] rx, ry;
    logic        seen;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_busy",      {63'd0, busy},      64'd0);
    check_eq("rst_result",    result,             64'd0);
    check_eq("rst_state",     {62'd0, dbg_state}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    do_op("mul",    4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    do_op("mulh",   4'd1,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 0);
    do_op("div",    4'd4,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    do_op("rem",    4'd6,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    do_op("divu",   4'd5,  64'd20, 64'd3, 64'd6, 0);
    do_op("remu",   4'd7,  64'd20, 64'd3, 64'd2, 0);
    do_op("divu0",  4'd5,  64'd5, 64'd0, ONES, 0);
    do_op("removf", 4'd6,  MIN64, ONES, 64'd0, 0);
    do_op("divovf", 4'd4,  MIN64, ONES, MIN64, 0);
    do_op("ill14",  4'd14, 64'h1234_5678_9ABC_DEF0, 64'd3, 64'd0, 0);
    do_op("mulw",   4'd8,  64'h0000_0001_0000_4000, 64'h0000_0000_0002_0000, 64'hFFFF_FFFF_8000_0000, 0);
    do_op("divuw",  4'd10, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 0);
    do_op("remuw0", 4'd12, 64'h0000_0000_8000_0001, 64'hFFFF_0000_0000_0000, 64'hFFFF_FFFF_8000_0001, 0);
    do_op("bp",     4'd0,  64'd12345, 64'd678, 64'h0000_0000_007F_B6F6, 10);

    // Flush during a divide: no result may ever appear.
    @(negedge clk);
    op = 4'd4; a = 64'hFFFF_FFFF_FFFF_FFEC; b = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy",     {63'd0, busy},     64'd0);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("flush_no_valid", {63'd0, seen}, 64'd0);
    do_op("mulhu", 4'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 0);

    // Flush in DONE while a new request is presented: result dropped, request refused.
    @(negedge clk);
    op = 4'd13; a = 64'd1; b = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("fast_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 4'd5; a = 64'd100; b = 64'd7;
    @(posedge clk); #1;
    check_eq("flushdone_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flushdone_busy",  {63'd0, busy},      64'd0);
    @(posedge clk); #1;
    check_eq("flush_refuse_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 4'd0; a = 64'd99; b = 64'd77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_busy",      {63'd0, busy},      64'd0);
    check_eq("midrst_result",    result,             64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("post_rst", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, ONES, 0);

    // Randomized ops with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ry = {$urandom, 32'h0};
        1: begin
          if (ro >= 4'd8) begin
            rx = {$urandom, 32'h8000_0000};
            ry = {$urandom, 32'hFFFF_FFFF};
          end else begin
            rx = MIN64;
            ry = ONES;
          end
        end
        2: begin
          rx = 64'($urandom_range(0, 1000));
          ry = 64'($urandom_range(1, 50));
          if ($urandom_range(0, 1) == 1) rx = -rx;
          if ($urandom_range(0, 1) == 1) ry = -ry;
        end
        default: ;
      endcase
      do_op("rnd", ro, rx, ry, ref_result(ro, rx, ry), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised, multi-cycle multiply/divide unit for the execute stage. It covers the RV64M operation set, including the W (32-bit) forms.
- It sits beside the single-cycle combinational ALU. It owns the ops that cannot complete in one cycle.
- Operands enter through a valid/ready handshake. The unit iterates one bit per cycle (shift-add multiply, restoring divide) and returns one registered result through a second valid/ready handshake.
- One operation is in flight at a time. A flush cancels it.

Parameters:
- XLEN, 64, datapath width. Must be 64 when W ops are used; 32 is also legal, and then ops 8-12 are treated as illegal.
- OPW, 4, op-code width.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous cancel of any in-flight or completed-but-unconsumed op.
- in_valid  input  1  request is valid.
- in_ready  output  1  unit can accept a request this cycle.
- op  input  OPW  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW, 13-15 illegal.
- a  input  XLEN  operand A (rs1).
- b  input  XLEN  operand B (rs2).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  registered result.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all internal registers 0.
- FSM states: IDLE, BUSY, DONE.
- Acceptance: a request is accepted when in_valid && in_ready. in_ready=1 only in IDLE. op, a and b are captured on the accepting edge; later changes to the inputs are ignored.
- IDLE -> BUSY on accept, loading iteration counter cnt = N.
  - N = XLEN for ops 0-7.
  - N = 32 for ops 8-12.
- IDLE -> DONE directly on accept (fast path; out_valid high the next cycle) for:
  - Divide/remainder with divisor == 0, where the divisor is the low 32 bits for W ops:
    - DIV/DIVU/DIVW/DIVUW give all ones, sign-extended for W.
    - REM/REMU/REMW/REMUW give the dividend, sign-extended from bit 31 for W.
  - Signed overflow (dividend = most-negative, divisor = -1):
    - DIV/DIVW give the dividend.
    - REM/REMW give 0.
  - Illegal op: result=0.
- BUSY: one iteration per cycle; cnt decrements each cycle. When cnt reaches 0 the final result is written and the FSM goes to DONE.
  - Normal op latency: accept edge to out_valid rising is exactly N+1 cycles (65 for 64-bit ops, 33 for W ops).
- Operand preparation for signed ops: operand magnitudes are taken at capture and the result sign is applied on the final iteration.
  - MUL/MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - DIV/REM: both operands signed.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- W ops: operands are the low 32 bits, sign- or zero-extended per op. The result is the 32-bit result sign-extended from bit 31 (DIVUW/REMUW included).
- Multiply result selection:
  - MUL/MULW give the low XLEN (or low 32, then extended) bits of the 2*XLEN product.
  - MULH/MULHSU/MULHU give the high XLEN bits.
- DONE: out_valid=1 and result is held stable until out_valid && out_ready. On that edge the FSM goes to IDLE and out_valid drops. A new request is accepted no earlier than the following cycle, so there is no back-to-back overlap.
- Flush:
  - Flush in any state forces IDLE on the next edge, with out_valid=0. result keeps its old value but is not valid.
  - Flush has priority over accept and over result consumption in the same cycle. A request presented with flush is not accepted.
- Reset mid-operation: immediate return to the reset values; no result is produced.
- busy is a pure decode of state (BUSY or DONE).

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), out_ready=1 -> out_valid high exactly 65 cycles after accept, result 0xFFFF_FFFF_FFFF_FFEB. Repeat with MULH -> result 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-20, b=3 -> result -6 (0xFFFF_FFFF_FFFF_FFFA); REM with the same operands -> result -2; DIVU a=20, b=3 -> 6; REMU with the same operands -> 2.
- DIVU b=0, a=5 -> out_valid the cycle after accept, result 0xFFFF_FFFF_FFFF_FFFF. REM with a=0x8000_0000_0000_0000, b=-1 -> result 0 on the fast path. Op 14 -> result 0 on the fast path.
- MULW a=0x0000_0001_0000_4000, b=0x0002_0000 -> 33-cycle latency, result 0xFFFF_FFFF_8000_0000. DIVUW a=0xFFFF_FFFF, b=1 -> result 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid and result stable, in_ready=0. Raising out_ready -> IDLE the next cycle, and in_ready=1 from then.
- Flush asserted at cycle 20 of a DIV -> IDLE next cycle with out_valid never asserted. A new MULHU a=b=0xFFFF_FFFF_FFFF_FFFF then gives 0xFFFF_FFFF_FFFF_FFFE. Asserting reset mid-BUSY returns all outputs to their reset values immediately.
